// File: rtl/im_port_arbiter.sv
// Instruction-memory port arbiter: shares one single-port memory between the
// fetch stage and a loader/debug port, with starvation protection and lock mode.
module im_port_arbiter #(
  parameter logic [31:0] BIAS          = 32'h0000_3000,
  parameter int          ADDR_W        = 12,
  parameter int          MAX_FETCH_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic [31:0]       f_rdata,
  output logic              f_stall,
  output logic              f_exc,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_lock,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              ld_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Loader handshake: a request transfers in any cycle where ld_valid and
  // ld_ready are both high; the requester holds its fields until then.

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    YIELD = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_FETCH_RUN);

  state_t      state;
  logic [3:0]  run_cnt;
  logic [3:0]  run_cnt_inc;

  logic [31:0]       f_off;
  logic [31:0]       ld_off;
  logic              f_ok;
  logic              ld_ok;
  logic [ADDR_W-1:0] f_idx;
  logic [ADDR_W-1:0] ld_idx;

  logic f_pend;
  logic ld_pend;
  logic f_gnt;
  logic ld_gnt;
  logic yield_due;

  // Same window check on both ports: word aligned and inside [BIAS, BIAS + 4*2^ADDR_W).
  always_comb begin
    f_off  = f_addr - BIAS;
    ld_off = ld_addr - BIAS;
    f_ok   = (f_addr[1:0] == 2'b00) && (f_addr >= BIAS) && ((f_off >> (ADDR_W + 2)) == 32'd0);
    ld_ok  = (ld_addr[1:0] == 2'b00) && (ld_addr >= BIAS) && ((ld_off >> (ADDR_W + 2)) == 32'd0);
    f_idx  = f_off[ADDR_W+1:2];
    ld_idx = ld_off[ADDR_W+1:2];
  end

  always_comb begin
    f_pend  = f_req && f_ok;
    ld_pend = ld_valid && ld_ok;
    f_gnt   = 1'b0;
    ld_gnt  = 1'b0;
    case (state)
      LOCK: begin
        ld_gnt = ld_pend;
      end
      YIELD: begin
        ld_gnt = ld_pend;
        f_gnt  = f_pend && !ld_pend;
      end
      default: begin
        f_gnt  = f_pend;
        ld_gnt = ld_pend && !f_pend;
      end
    endcase
  end

  // Out-of-range loader requests never need the port, so they are taken at once.
  always_comb begin
    f_exc     = f_req && !f_ok;
    f_stall   = f_pend && !f_gnt;
    f_rdata   = f_gnt ? mem_rdata : 32'd0;
    ld_ready  = ld_gnt || (ld_valid && !ld_ok);
    mem_we    = ld_gnt && ld_we;
    mem_addr  = ld_gnt ? ld_idx : f_idx;
    mem_wdata = ld_wdata;
  end

  always_comb begin
    run_cnt_inc = run_cnt + 4'd1;
    yield_due   = ld_valid && !ld_ready && f_gnt && (run_cnt_inc == MAX_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      run_cnt   <= 4'd0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= 32'd0;
      ld_err    <= 1'b0;
    end else begin
      ld_rvalid <= ld_ready && !ld_we;
      ld_err    <= ld_ready && !ld_ok;
      if (ld_ready && !ld_we) begin
        ld_rdata <= ld_ok ? mem_rdata : 32'd0;
      end

      if (ld_lock || ld_ready || !ld_valid) begin
        run_cnt <= 4'd0;
      end else if (f_gnt) begin
        run_cnt <= run_cnt_inc;
      end

      if (ld_lock) begin
        state <= LOCK;
      end else if (state == LOCK) begin
        state <= RUN;
      end else if (yield_due) begin
        state <= YIELD;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run checked against an ownership-level model.
module tb_im_port_arbiter;

  localparam logic [31:0] BIAS   = 32'h0000_3000;
  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          MAXRUN = 4;

  logic              clk;
  logic              rst;
  logic              f_req;
  logic [31:0]       f_addr;
  logic [31:0]       f_rdata;
  logic              f_stall;
  logic              f_exc;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_lock;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;
  logic              ld_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  im_port_arbiter #(
    .BIAS(BIAS), .ADDR_W(ADDR_W), .MAX_FETCH_RUN(MAXRUN)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_stall(f_stall), .f_exc(f_exc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_lock(ld_lock), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_err(ld_err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory behind the port ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h2408_000A : (32'hC0DE_0000 | 32'(i));
  endfunction

  logic [31:0] wr_d [0:DEPTH-1];
  bit          wr_v [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_we) begin
      wr_v[mem_addr] <= 1'b1;
      wr_d[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = wr_v[mem_addr] ? wr_d[mem_addr] : init_word(int'(mem_addr));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership view: normal (fetch first), owed (loader first), locked (loader only).
  localparam int M_NORMAL = 0;
  localparam int M_OWED   = 1;
  localparam int M_LOCKED = 2;

  int          m_mode;
  int          m_waits;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [int];

  function automatic bit addr_ok(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BIAS);
    return (a % 4 == 0) && (off >= 0) && (off < 4 * DEPTH);
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BIAS;
    return int'((off / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] ref_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  task automatic model_reset();
    m_mode  = M_NORMAL;
    m_waits = 0;
    m_rdata = 32'd0;
  endtask

  // Last sampled DUT values, for the hand-written expectations.
  logic        a_f_stall, a_f_exc, a_ld_ready, a_mem_we, a_rvalid, a_err;
  logic [31:0] a_f_rdata, a_rdata;

  // Called at a falling edge; applies one cycle, checks it, returns at the next falling edge.
  task automatic cycle(input logic fr, input logic [31:0] fa, input logic lv, input logic lw,
                       input logic [31:0] la, input logic [31:0] ldat, input logic lk);
    bit fv, lvv, lbad, e_ready, e_we, e_rv;
    int owner;  // 0 none, 1 fetch, 2 loader
    int fidx, lidx, prev_mode;
    f_req = fr; f_addr = fa; ld_valid = lv; ld_we = lw; ld_addr = la; ld_wdata = ldat; ld_lock = lk;
    #2;
    fv   = fr && addr_ok(fa);
    lvv  = lv && addr_ok(la);
    lbad = lv && !addr_ok(la);
    fidx = addr_idx(fa);
    lidx = addr_idx(la);
    if (m_mode == M_LOCKED)    owner = lvv ? 2 : 0;
    else if (m_mode == M_OWED) owner = lvv ? 2 : (fv ? 1 : 0);
    else                       owner = fv ? 1 : (lvv ? 2 : 0);
    e_ready = (owner == 2) || lbad;
    e_we    = (owner == 2) && lw;

    a_f_stall = f_stall; a_f_exc = f_exc; a_ld_ready = ld_ready;
    a_mem_we = mem_we; a_f_rdata = f_rdata;
    chk("f_exc", 32'(f_exc), 32'(fr && !addr_ok(fa)));
    chk("f_stall", 32'(f_stall), 32'(fv && owner != 1));
    chk("f_rdata", f_rdata, (owner == 1) ? ref_rd(fidx) : 32'd0);
    chk("ld_ready", 32'(ld_ready), 32'(e_ready));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'((owner == 2) ? lidx : fidx));
    if (e_we) chk("mem_wdata", mem_wdata, ldat);

    @(posedge clk);
    #1;
    e_rv = e_ready && !lw;
    if (e_rv) m_rdata = lbad ? 32'd0 : ref_rd(lidx);
    a_rvalid = ld_rvalid; a_err = ld_err; a_rdata = ld_rdata;
    chk("ld_rvalid", 32'(ld_rvalid), 32'(e_rv));
    chk("ld_err", 32'(ld_err), 32'(lbad));
    chk("ld_rdata", ld_rdata, m_rdata);
    if (e_we) ref_mem[lidx] = ldat;

    prev_mode = m_mode;
    if (lk || e_ready || !lv) m_waits = 0;
    else if (owner == 1)      m_waits++;
    if (lk)                          m_mode = M_LOCKED;
    else if (prev_mode == M_LOCKED)  m_mode = M_NORMAL;
    else if (m_waits == MAXRUN)      m_mode = M_OWED;
    else                             m_mode = M_NORMAL;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)  return BIAS + 32'(4 * $urandom_range(0, 7));
    if (r == 8) return BIAS + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
    return ($urandom_range(0, 1) == 0) ? 32'h0000_2FF0 : 32'h0000_7000 + 32'(4 * $urandom_range(0, 3));
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lv;
    logic        lw;
    logic [31:0] la;
    logic [31:0] ldat;
    logic        e_exc;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic [31:0] e_rdata;
    logic        e_rv;
    logic        e_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lock_left;
    logic [31:0] lock_exp [3];

    vecs[0] = '{1'b1, 32'h2FFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h3002, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h6FFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0FFF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h7000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h7000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h7000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h2FFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h3000, 1'b1, 1'b1, 32'h300C, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2408_000A, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h3001, 1'b1, 1'b1, 32'h300C, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'h2FFC, 1'b1, 1'b0, 32'h7000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1};

    // Reset with a fetch of the reset PC pending.
    rst = 1'b0; f_req = 1'b1; f_addr = BIAS; ld_valid = 1'b0; ld_we = 1'b0;
    ld_addr = 32'd0; ld_wdata = 32'd0; ld_lock = 1'b0;
    model_reset();
    #2;
    chk("rst_f_rdata", f_rdata, 32'h2408_000A);
    chk("rst_f_stall", 32'(f_stall), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst_ld_rdata", ld_rdata, 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Vector table, each entry followed by an idle cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].fr, vecs[i].fa, vecs[i].lv, vecs[i].lw, vecs[i].la, vecs[i].ldat, 1'b0);
      chk($sformatf("vec%0d_f_exc", i), 32'(a_f_exc), 32'(vecs[i].e_exc));
      chk($sformatf("vec%0d_f_stall", i), 32'(a_f_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_ld_ready", i), 32'(a_ld_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_mem_we", i), 32'(a_mem_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_f_rdata", i), a_f_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_ld_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_ld_err", i), 32'(a_err), 32'(vecs[i].e_err));
      idle();
    end

    // Starvation: four fetch grants, then one loader grant, then fetch again.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, BIAS + 32'(4 * i), 1'b1, 1'b0, 32'h3010, 32'd0, 1'b0);
      chk($sformatf("starve%0d_f_stall", i), 32'(a_f_stall), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d_ld_ready", i), 32'(a_ld_ready), (i == 4) ? 32'd1 : 32'd0);
    end
    idle();

    // Write then fetch of the same word on the next cycle.
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h3004, 32'h1234_5678, 1'b0);
    chk("wtf_mem_we", 32'(a_mem_we), 32'd1);
    cycle(1'b1, 32'h3004, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("wtf_f_rdata", a_f_rdata, 32'h1234_5678);

    // Lock: raised one cycle ahead, then three locked reads, then release.
    lock_exp[0] = 32'h2408_000A; lock_exp[1] = 32'h1234_5678; lock_exp[2] = 32'hC0DE_0002;
    cycle(1'b1, BIAS, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("lock_entry_f_stall", 32'(a_f_stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h3010, 1'b1, 1'b0, BIAS + 32'(4 * i), 32'd0, 1'b1);
      chk($sformatf("lock%0d_f_stall", i), 32'(a_f_stall), 32'd1);
      chk($sformatf("lock%0d_ld_ready", i), 32'(a_ld_ready), 32'd1);
      chk($sformatf("lock%0d_ld_rvalid", i), 32'(a_rvalid), 32'd1);
      chk($sformatf("lock%0d_ld_rdata", i), a_rdata, lock_exp[i]);
    end
    cycle(1'b1, 32'h3010, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("unlock_edge_f_stall", 32'(a_f_stall), 32'd1);
    cycle(1'b1, 32'h3010, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("unlock_run_f_stall", 32'(a_f_stall), 32'd0);

    // Reset right at the edge that would deliver a locked read response.
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    f_req = 1'b0; ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 32'h3008; ld_lock = 1'b1;
    #2;
    chk("rstmid_accept", 32'(ld_ready), 32'd1);
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rstmid_ld_rdata", ld_rdata, 32'd0);
    f_req = 1'b1; f_addr = BIAS; ld_addr = 32'h3004; ld_lock = 1'b0;
    #1;
    chk("rstmid_run_f_stall", 32'(f_stall), 32'd0);
    chk("rstmid_run_ld_ready", 32'(ld_ready), 32'd0);
    chk("rstmid_run_f_rdata", f_rdata, 32'h2408_000A);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Randomized traffic with occasional lock bursts.
    lock_left = 0;
    for (int n = 0; n < 600; n++) begin
      logic lk;
      if (lock_left == 0 && $urandom_range(0, 30) == 0) lock_left = $urandom_range(1, 5);
      lk = (lock_left > 0);
      if (lock_left > 0) lock_left--;
      cycle($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, rand_addr(), $urandom, lk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
